// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared datapath widths, zero-register index and ALU op encodings
package datapath_pkg;

  localparam int SIZE     = 32;
  localparam int ADDR     = 5;
  localparam int ZERO_REG = 0;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_e;

  // Reference ALU result so decode, regfile and bench agree on op meaning; SLT is signed.
  function automatic logic [SIZE-1:0] alu_eval(alu_op_e op, logic [SIZE-1:0] a, logic [SIZE-1:0] b);
    logic [SIZE-1:0] r;
    r = '0;
    case (op)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_SLT: r = ($signed(a) < $signed(b)) ? SIZE'(1) : '0;
      ALU_NOR: r = ~(a | b);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational register-file read port
// Zero-register check first, then optional same-cycle write bypass, then stored value.
module rf_read_port #(
  parameter int SIZE   = datapath_pkg::SIZE,
  parameter int ADDR   = datapath_pkg::ADDR,
  parameter bit BYPASS = 1'b1
) (
  input  logic [ADDR-1:0] ra,
  input  logic [SIZE-1:0] stored,
  input  logic            we,
  input  logic [ADDR-1:0] wa,
  input  logic [SIZE-1:0] wd,
  output logic [SIZE-1:0] rd
);
  import datapath_pkg::ZERO_REG;

  logic hit;

  always_comb begin
    hit = BYPASS && we && (ra == wa);
    if (ra == ADDR'(ZERO_REG)) begin
      rd = '0;
    end else if (hit) begin
      rd = wd;
    end else begin
      rd = stored;
    end
  end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2R1W register file with r0 hardwired to zero, optional bypass,
// debug read port and saturating committed-write counter.
module reg_file #(
  parameter int SIZE   = datapath_pkg::SIZE,
  parameter int ADDR   = datapath_pkg::ADDR,
  parameter bit BYPASS = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADDR-1:0]  ra1,
  input  logic [ADDR-1:0]  ra2,
  output logic [SIZE-1:0]  rd1,
  output logic [SIZE-1:0]  rd2,
  input  logic             we,
  input  logic [ADDR-1:0]  wa,
  input  logic [SIZE-1:0]  wd,
  input  logic [ADDR-1:0]  dbg_addr,
  output logic [SIZE-1:0]  dbg_data,
  output logic [CNT_W-1:0] wr_cnt
);
  import datapath_pkg::ZERO_REG;

  localparam int DEPTH = 2 ** ADDR;

  logic [SIZE-1:0]  regs_q [DEPTH];
  logic [SIZE-1:0]  regs_d [DEPTH];
  logic [CNT_W-1:0] wr_cnt_q;
  logic [CNT_W-1:0] wr_cnt_d;
  logic             commit;
  logic             rd_we;

  always_comb begin
    commit   = we && (wa != ADDR'(ZERO_REG));
    regs_d   = regs_q;
    wr_cnt_d = wr_cnt_q;
    if (commit) begin
      regs_d[wa] = wd;
      if (wr_cnt_q != '1) begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q   <= '{default: '0};
      wr_cnt_q <= '0;
    end else begin
      regs_q   <= regs_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // A write during reset is discarded, so it must not leak through the bypass either.
  assign rd_we  = we & ~rst;
  assign wr_cnt = wr_cnt_q;

  rf_read_port #(.SIZE(SIZE), .ADDR(ADDR), .BYPASS(BYPASS)) u_port1 (
    .ra(ra1), .stored(regs_q[ra1]), .we(rd_we), .wa(wa), .wd(wd), .rd(rd1)
  );

  rf_read_port #(.SIZE(SIZE), .ADDR(ADDR), .BYPASS(BYPASS)) u_port2 (
    .ra(ra2), .stored(regs_q[ra2]), .we(rd_we), .wa(wa), .wd(wd), .rd(rd2)
  );

  rf_read_port #(.SIZE(SIZE), .ADDR(ADDR), .BYPASS(1'b0)) u_port_dbg (
    .ra(dbg_addr), .stored(regs_q[dbg_addr]), .we(rd_we), .wa(wa), .wd(wd), .rd(dbg_data)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file (bypass, no-bypass and 2-bit counter builds)
module tb_reg_file;
  import datapath_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  ra1 = '0, ra2 = '0, wa = '0, dbg_addr = '0;
  logic [31:0] wd = '0;

  logic [31:0] rd1_a, rd2_a, dbg_a, rd1_b, rd2_b, dbg_b, rd1_c, rd2_c, dbg_c;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  logic [31:0] mem [32] = '{default: '0};
  int          n_commits = 0;
  int          sat_seq [5] = '{1, 2, 3, 3, 3};

  always #5 clk = ~clk;

  reg_file #(.SIZE(32), .ADDR(5), .BYPASS(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
    .we(we), .wa(wa), .wd(wd), .dbg_addr(dbg_addr), .dbg_data(dbg_a), .wr_cnt(cnt_a)
  );

  reg_file #(.SIZE(32), .ADDR(5), .BYPASS(1'b0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .we(we), .wa(wa), .wd(wd), .dbg_addr(dbg_addr), .dbg_data(dbg_b), .wr_cnt(cnt_b)
  );

  reg_file #(.SIZE(32), .ADDR(5), .BYPASS(1'b1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_c), .rd2(rd2_c),
    .we(we), .wa(wa), .wd(wd), .dbg_addr(dbg_addr), .dbg_data(dbg_c), .wr_cnt(cnt_c)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    else passed++;
  endtask

  // Architectural model: registers as a plain array, counter as a count of commits.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      n_commits <= 0;
    end else if (we && wa != 5'd0) begin
      mem[wa]   <= wd;
      n_commits <= n_commits + 1;
    end
  end

  function automatic logic [31:0] exp_rd(logic [4:0] a, bit byp);
    if (rst || a == 5'd0) return '0;
    if (byp && we && a == wa) return wd;
    return mem[a];
  endfunction

  function automatic int sat(int n, int mx);
    return (n > mx) ? mx : n;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a.rd1", rd1_a, exp_rd(ra1, 1'b1));
      chk("a.rd2", rd2_a, exp_rd(ra2, 1'b1));
      chk("a.dbg", dbg_a, exp_rd(dbg_addr, 1'b0));
      chk("a.cnt", 32'(cnt_a), 32'(sat(n_commits, 65535)));
      chk("b.rd1", rd1_b, exp_rd(ra1, 1'b0));
      chk("b.rd2", rd2_b, exp_rd(ra2, 1'b0));
      chk("b.dbg", dbg_b, exp_rd(dbg_addr, 1'b0));
      chk("b.cnt", 32'(cnt_b), 32'(sat(n_commits, 65535)));
      chk("c.rd1", rd1_c, exp_rd(ra1, 1'b1));
      chk("c.rd2", rd2_c, exp_rd(ra2, 1'b1));
      chk("c.dbg", dbg_c, exp_rd(dbg_addr, 1'b0));
      chk("c.cnt", 32'(cnt_c), 32'(sat(n_commits, 3)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    #2 chk_en = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset pulse between edges clears state without a clock edge
    we = 1'b1; wa = 5'd9; wd = 32'hDEAD_BEEF; step();
    we = 1'b0; dbg_addr = 5'd9; ra1 = 5'd9; ra2 = 5'd9;
    #1 chk("pre_rst_dbg", dbg_a, 32'hDEAD_BEEF);
    rst = 1'b1;
    #1;
    chk("rst_cnt_now", 32'(cnt_a), 32'h0);
    chk("rst_dbg_now", dbg_a, 32'h0);
    chk("rst_rd1_now", rd1_a, 32'h0);
    chk("rst_rd2_now", rd2_a, 32'h0);
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a); dbg_addr = 5'(a);
      we = a[0]; wa = 5'(a); wd = 32'hFFFF_0000 | 32'(a);
      step();
    end
    we = 1'b0;
    rst = 1'b0;

    // Basic write then read
    we = 1'b1; wa = 5'd5; wd = 32'h1234_5678; ra1 = '0; ra2 = '0; step();
    we = 1'b0; ra1 = 5'd5; ra2 = 5'd5;
    #1;
    chk("t2_rd1", rd1_a, 32'h1234_5678);
    chk("t2_rd2", rd2_a, 32'h1234_5678);
    chk("t2_cnt", 32'(cnt_a), 32'd1);

    // Writes to r0 are ignored, including through the bypass
    step();
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0;
    #1 chk("t3_rd1_byp", rd1_a, 32'h0);
    step();
    we = 1'b0;
    #1;
    chk("t3_rd1", rd1_a, 32'h0);
    chk("t3_cnt", 32'(cnt_a), 32'd1);

    // Bypass vs no-bypass, debug port never bypassed
    we = 1'b1; wa = 5'd7; wd = 32'hA; step();
    wd = 32'hB; ra1 = 5'd7; dbg_addr = 5'd7;
    #1;
    chk("t4_byp_rd1", rd1_a, 32'hB);
    chk("t4_byp_dbg", dbg_a, 32'hA);
    chk("t4_nobyp_rd1", rd1_b, 32'hA);
    step();
    we = 1'b0;
    #1;
    chk("t4_after_a", rd1_a, 32'hB);
    chk("t4_after_b", rd1_b, 32'hB);

    // Both ports bypass together; back-to-back writes are last-writer-wins
    we = 1'b1; wa = 5'd12; wd = 32'h55; ra1 = 5'd12; ra2 = 5'd12;
    #1;
    chk("dual_byp_rd1", rd1_a, 32'h55);
    chk("dual_byp_rd2", rd2_a, 32'h55);
    step();
    wd = 32'h66; step();
    wd = 32'h77; step();
    we = 1'b0;
    #1 chk("last_writer", rd2_b, 32'h77);

    // Operands into the ALU
    we = 1'b1; wa = 5'd1; wd = 32'd3; step();
    wa = 5'd2; wd = 32'd10; step();
    we = 1'b0; ra1 = 5'd1; ra2 = 5'd2;
    #1;
    chk("t5_rd1", rd1_a, 32'd3);
    chk("t5_rd2", rd2_a, 32'd10);
    chk("t5_sub", alu_eval(ALU_SUB, rd1_a, rd2_a), 32'hFFFF_FFF9);
    chk("t5_zero", 32'(alu_eval(ALU_SUB, rd1_a, rd2_a) == '0), 32'd0);
    chk("t5_slt", alu_eval(ALU_SLT, rd1_a, rd2_a), 32'd1);
    step();

    // Counter saturation on the 2-bit build
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      we = 1'b1; wa = 5'(3 + i); wd = 32'(i * 17 + 1);
      step();
      chk($sformatf("t6_cnt%0d", i), 32'(cnt_c), 32'(sat_seq[i]));
    end
    we = 1'b0;
    rst = 1'b1;
    #1 chk("t6_rst_cnt", 32'(cnt_c), 32'd0);
    rst = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Register file feeding operands rd1/rd2 directly into the ALU stage of the single-cycle datapath.
- Two combinational read ports and one synchronous write port; register 0 is hardwired to zero.
- Optional write-to-read bypass, so a same-cycle write is visible to the ALU when BYPASS=1.
- Debug read port for bench and board inspection, plus a saturating count of committed writes.

Parameters:
SIZE, 32, data width in bits; must match the ALU SIZE.
ADDR, 5, address width; depth = 2**ADDR registers.
BYPASS, 1, 1 = a read of the address being written returns wd in the same cycle; 0 = the read returns the stored (old) value.
CNT_W, 16, width of the write counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
ra1  input  ADDR  read address, port 1.
ra2  input  ADDR  read address, port 2.
rd1  output  SIZE  read data, port 1 (to ALU rd1).
rd2  output  SIZE  read data, port 2 (to ALU rd2).
we  input  1  write enable.
wa  input  ADDR  write address.
wd  input  SIZE  write data (from ALU rez or memory).
dbg_addr  input  ADDR  debug read address.
dbg_data  output  SIZE  debug read data; never bypassed.
wr_cnt  output  CNT_W  number of committed writes since reset.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset:
  - While rst=1, all registers are 0 and wr_cnt is 0; reset takes effect immediately, with no clock edge needed.
  - rd1, rd2 and dbg_data therefore read 0 during reset.
  - A write presented in the same cycle as reset is discarded.
- Write:
  - On a rising clk edge with rst=0, we=1 and wa!=0, reg[wa] takes wd.
  - wa=0 with we=1 is ignored: no state change and wr_cnt does not increment.
- Write counter:
  - wr_cnt increments by 1 on each committed write.
  - It saturates at 2**CNT_W-1 and does not wrap.
- Read (combinational, zero latency):
  - rdN = 0 when raN=0.
  - Else, when BYPASS=1, we=1 and raN==wa, rdN = wd.
  - Else rdN = reg[raN].
  - Both ports may read the same address; both ports may hit the bypass simultaneously.
- Debug port: dbg_data = reg[dbg_addr], or 0 when dbg_addr=0; it shows the pre-edge value during a write cycle.
- Timing:
  - A non-bypassed read of a just-written register sees the new value in the cycle after the edge.
  - Back-to-back writes to the same address resolve last-writer-wins per edge.
- Reset mid-operation: asserting rst between edges clears the state at once; the next edge after deassertion behaves normally.
- Width rules:
  - No width conversion inside the block.
  - Addresses are unsigned.
  - All 2**ADDR entries are reachable, with no out-of-range case.

Decomposition:
- Shared package (datapath_pkg):
  - SIZE default 32 and ADDR default 5.
  - ZERO_REG = 0.
  - ALU op encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, so decode and regfile stages share one source.
- One sub-module, rf_read_port:
  - Contains the zero check, bypass compare and mux.
  - Instantiated three times: ports 1 and 2 with BYPASS as configured, debug with bypass disabled.
- Storage array, write logic and counter stay in reg_file.

Test Plan:
1. Reset: pulse rst between edges. Then rd1, rd2 and dbg_data = 0 for all addresses, and wr_cnt = 0 immediately, before any clock edge.
2. Basic write/read: write wa=5, wd=0x12345678, then ra1=5 and ra2=5 next cycle. rd1 = rd2 = 0x12345678 and wr_cnt = 1.
3. Zero register: we=1, wa=0, wd=0xFFFFFFFF, then ra1=0. rd1 = 0 and wr_cnt unchanged, including in the bypass cycle.
4. Bypass:
   - BYPASS=1: reg[7]=0xA, write wa=7, wd=0xB, with ra1=7 in the same cycle. rd1 = 0xB and dbg_data(7) = 0xA; after the edge rd1 = 0xB.
   - BYPASS=0: the same sequence gives rd1 = 0xA in that cycle.
5. ALU pairing: write r1=3 and r2=10, read ra1=1 and ra2=2 into the ALU with op 0110. ALU rez = 0xFFFFFFF9 and zero = 0; with op 0111, rez = 1.
6. Counter saturation: CNT_W=2, 5 committed writes. wr_cnt sequence 1, 2, 3, 3, 3; then assert rst mid-cycle and wr_cnt = 0.
